// File: rtl/inta_sequencer_pkg.sv
// Shared types, widths and the priority-resolve helper for the INTA sequencer.
package inta_sequencer_pkg;

  localparam int unsigned LEVEL_W = 3;
  localparam int unsigned TBASE_W = 5;
  localparam int unsigned IRQ_W   = 8;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_WAIT2  = 2'd2,
    ST_SECOND = 2'd3
  } state_t;

  typedef struct packed {
    logic [TBASE_W-1:0] base;
    logic [LEVEL_W-1:0] level;
  } vector_t;

  // Lowest set index wins; an empty request word resolves to the lowest priority level.
  function automatic logic [LEVEL_W-1:0] resolve_level(input logic [IRQ_W-1:0] req);
    logic [LEVEL_W-1:0] lvl;
    lvl = LEVEL_W'(IRQ_W - 1);
    for (int i = IRQ_W - 1; i >= 0; i--) begin
      if (req[i]) lvl = LEVEL_W'(i);
    end
    return lvl;
  endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// CPU/controller-facing signal bundle of the INTA sequencer.
interface inta_sequencer_if;
  import inta_sequencer_pkg::*;

  logic                inta_n;
  logic [IRQ_W-1:0]    irr;
  logic [TBASE_W-1:0]  icw2_t;
  logic [IRQ_W-1:0]    icw3;
  logic                sp_en;
  logic                sngl;
  logic                aeoi;
  logic                selected_slave;
  logic                inta_first_pulse;
  logic                inta_second_pulse;
  logic [IRQ_W-1:0]    isr_set;
  logic [IRQ_W-1:0]    isr_clr;
  logic [LEVEL_W-1:0]  int_level;
  logic [7:0]          data_out;
  logic                data_oe;
  logic                timeout_err;

  modport master (
    output inta_n, irr, icw2_t, icw3, sp_en, sngl, aeoi, selected_slave,
    input  inta_first_pulse, inta_second_pulse, isr_set, isr_clr, int_level,
           data_out, data_oe, timeout_err
  );

  modport slave (
    input  inta_n, irr, icw2_t, icw3, sp_en, sngl, aeoi, selected_slave,
    output inta_first_pulse, inta_second_pulse, isr_set, isr_clr, int_level,
           data_out, data_oe, timeout_err
  );
endinterface

// File: rtl/inta_sequencer_edge_sync.sv
// Synchronises the asynchronous INTA_N and derives single-cycle fall/rise strobes.
module inta_sequencer_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_n,
  output logic fall_c,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Presetting to 1 keeps reset release from looking like an acknowledge edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_n};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign fall_c = prev & ~chain[SYNC_STAGES-1];
  assign rise_c = ~prev & chain[SYNC_STAGES-1];

endmodule

// File: rtl/inta_sequencer.sv
// INTA two-pulse responder: level latch, ISR set/clear strobes and vector drive.
module inta_sequencer
  import inta_sequencer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic           clk,
  input logic           rst_n,
  inta_sequencer_if.slave bus
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               spur;
  logic [LEVEL_W-1:0] level;
  logic               first_pulse;
  logic               second_pulse;
  logic [IRQ_W-1:0]   isr_set;
  logic [IRQ_W-1:0]   isr_clr;
  logic               oe;
  logic [7:0]         data_out;
  logic               tmo;

  logic               fall_c;
  logic               rise_c;
  logic               oe_c;
  logic [LEVEL_W-1:0] req_level_c;
  vector_t            vec_c;

  inta_sequencer_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_n(bus.inta_n),
    .fall_c (fall_c),
    .rise_c (rise_c)
  );

  // Bus ownership: single mode, master of a non-cascaded IR (or spurious), or selected slave.
  assign oe_c = bus.sngl
              | (bus.sp_en & (~bus.icw3[level] | spur))
              | (~bus.sp_en & bus.selected_slave);

  assign req_level_c = resolve_level(bus.irr);
  assign vec_c       = '{base: bus.icw2_t, level: level};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      spur         <= 1'b0;
      level        <= '0;
      first_pulse  <= 1'b0;
      second_pulse <= 1'b0;
      isr_set      <= '0;
      isr_clr      <= '0;
      oe           <= 1'b0;
      data_out     <= '0;
      tmo          <= 1'b0;
    end else begin
      isr_set <= '0;
      isr_clr <= '0;
      case (state)
        ST_IDLE: begin
          if (fall_c) begin
            state       <= ST_FIRST;
            first_pulse <= 1'b1;
            tmo         <= 1'b0;
            level       <= req_level_c;
            spur        <= (bus.irr == '0);
            isr_set     <= (bus.irr == '0) ? '0 : IRQ_W'(1) << req_level_c;
          end
        end
        ST_FIRST: begin
          if (rise_c) begin
            state       <= ST_WAIT2;
            first_pulse <= 1'b0;
            cnt         <= '0;
          end
        end
        ST_WAIT2: begin
          // Timeout is checked first so it wins over a coincident second fall.
          if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            state <= ST_IDLE;
            tmo   <= 1'b1;
            spur  <= 1'b0;
          end else if (fall_c) begin
            state        <= ST_SECOND;
            second_pulse <= 1'b1;
            oe           <= oe_c;
            data_out     <= oe_c ? vec_c : 8'h00;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SECOND: begin
          if (rise_c) begin
            state        <= ST_IDLE;
            second_pulse <= 1'b0;
            oe           <= 1'b0;
            data_out     <= 8'h00;
            spur         <= 1'b0;
            if (bus.aeoi && !spur) isr_clr <= IRQ_W'(1) << level;
          end else begin
            oe       <= oe_c;
            data_out <= oe_c ? vec_c : 8'h00;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.inta_first_pulse  = first_pulse;
  assign bus.inta_second_pulse = second_pulse;
  assign bus.isr_set           = isr_set;
  assign bus.isr_clr           = isr_clr;
  assign bus.int_level         = level;
  assign bus.data_out          = data_out;
  assign bus.data_oe           = oe;
  assign bus.timeout_err       = tmo;

endmodule
